// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_arbiter
//  Purpose  : Round-robin, burst-capped arbiter sharing one 15-bit/16-bit
//             Memory port between the CPU data port and the screen/DMA reader.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [14:0] m0_addr_i,
   input  logic [15:0] m0_wdata_i,
   output logic        m0_gnt_o,
   output logic        m0_rvalid_o,
   output logic [15:0] m0_rdata_o,

   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [14:0] m1_addr_i,
   input  logic [15:0] m1_wdata_i,
   output logic        m1_gnt_o,
   output logic        m1_rvalid_o,
   output logic [15:0] m1_rdata_o,

   output logic [15:0] mem_in_o,
   output logic [14:0] mem_address_o,
   output logic        mem_load_o,
   input  logic [15:0] mem_out_i
);

   localparam int            CW         = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0] C_CNT_LAST = CW'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN0 = 2'd1,
      S_OWN1 = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          m0_rvalid_q, m1_rvalid_q;
   logic [15:0]   m0_rdata_q, m1_rdata_q;

   logic          own_req, oth_req, own_acc;
   state_t        to_oth;

   // Grants are combinational so the owner can transfer every cycle.
   assign m0_gnt_o = (state_q == S_OWN0) & m0_req_i & rst_ni;
   assign m1_gnt_o = (state_q == S_OWN1) & m1_req_i & rst_ni;

   assign m0_rvalid_o = m0_rvalid_q;
   assign m1_rvalid_o = m1_rvalid_q;
   assign m0_rdata_o  = m0_rdata_q;
   assign m1_rdata_o  = m1_rdata_q;

   always_comb begin
      mem_address_o = '0;
      mem_in_o      = '0;
      mem_load_o    = 1'b0;
      if (rst_ni) begin
         if (state_q == S_OWN0) begin
            mem_address_o = m0_addr_i;
            mem_in_o      = m0_wdata_i;
            mem_load_o    = m0_gnt_o & m0_we_i;
         end else if (state_q == S_OWN1) begin
            mem_address_o = m1_addr_i;
            mem_in_o      = m1_wdata_i;
            mem_load_o    = m1_gnt_o & m1_we_i;
         end
      end
   end

   // Next owner, expressed relative to the current owner x and the other master y.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      own_req = 1'b0;
      oth_req = 1'b0;
      own_acc = 1'b0;
      to_oth  = S_IDLE;
      case (state_q)
         S_OWN0: begin
            own_req = m0_req_i;
            oth_req = m1_req_i;
            own_acc = m0_gnt_o;
            to_oth  = S_OWN1;
         end
         S_OWN1: begin
            own_req = m1_req_i;
            oth_req = m0_req_i;
            own_acc = m1_gnt_o;
            to_oth  = S_OWN0;
         end
         default: ;
      endcase

      if (state_q == S_IDLE) begin
         cnt_d = '0;
         if (m0_req_i) begin
            state_d = S_OWN0;
         end else if (m1_req_i) begin
            state_d = S_OWN1;
         end
      end else if (oth_req && !own_req) begin
         state_d = to_oth;
         cnt_d   = '0;
      end else if (oth_req && own_acc && (cnt_q == C_CNT_LAST)) begin
         state_d = to_oth;
         cnt_d   = '0;
      end else if (!own_req && !oth_req) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (!oth_req) begin
         cnt_d = '0;
      end else if (own_acc && (cnt_q != C_CNT_LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         m0_rvalid_q <= m0_gnt_o & ~m0_we_i;
         m1_rvalid_q <= m1_gnt_o & ~m1_we_i;
         // Read data is held after rvalid drops, so only load on a read accept.
         if (m0_gnt_o && !m0_we_i) begin
            m0_rdata_q <= mem_out_i;
         end
         if (m1_gnt_o && !m1_we_i) begin
            m1_rdata_q <= mem_out_i;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_arbiter
//  Purpose  : Self-checking bench for data_mem_arbiter with a Memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_arbiter;
   localparam int MAX_BURST = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, we0, req1, we1;
   logic [14:0] addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1, rv0, rv1, mem_load;
   logic [15:0] rd0, rd1, mem_in, mem_out;
   logic [14:0] mem_addr;

   logic [15:0] env_mem [0:32767];
   logic [15:0] ref_mem [0:32767];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mem_out = env_mem[mem_addr];
   always @(posedge clk) if (mem_load) env_mem[mem_addr] <= mem_in;

   data_mem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .m0_req_i(req0), .m0_we_i(we0), .m0_addr_i(addr0), .m0_wdata_i(wdata0),
      .m0_gnt_o(gnt0), .m0_rvalid_o(rv0), .m0_rdata_o(rd0),
      .m1_req_i(req1), .m1_we_i(we1), .m1_addr_i(addr1), .m1_wdata_i(wdata1),
      .m1_gnt_o(gnt1), .m1_rvalid_o(rv1), .m1_rdata_o(rd1),
      .mem_in_o(mem_in), .mem_address_o(mem_addr), .mem_load_o(mem_load),
      .mem_out_i(mem_out)
   );

   // Reference: who holds the turn (-1 none), and how many accepts the holder
   // has taken while the other master was waiting.
   int          holder = -1, streak = 0, n_holder, n_streak;
   logic        m_rv0 = 0, m_rv1 = 0, n_rv0, n_rv1, acc0 = 0, acc1 = 0;
   logic [15:0] m_rd0 = 0, m_rd1 = 0, n_rd0, n_rd1, wr_data;
   logic        wr_en;
   logic [14:0] wr_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_cycle();
      logic g0, g1, el, mine, theirs;
      logic [14:0] ea;
      logic [15:0] ed;
      if (!rst_n) begin
         holder = -1; streak = 0;
         m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0;
      end
      g0 = rst_n && holder == 0 && req0;
      g1 = rst_n && holder == 1 && req1;
      ea = (holder == 0) ? addr0  : (holder == 1) ? addr1  : 15'h0;
      ed = (holder == 0) ? wdata0 : (holder == 1) ? wdata1 : 16'h0;
      el = (g0 && we0) || (g1 && we1);
      chk("gnt0", gnt0, g0);
      chk("gnt1", gnt1, g1);
      chk("mem_load", mem_load, el);
      chk("mem_address", mem_addr, ea);
      chk("mem_in", mem_in, ed);
      chk("rvalid0", rv0, m_rv0);
      chk("rvalid1", rv1, m_rv1);
      chk("rdata0", rd0, m_rd0);
      chk("rdata1", rd1, m_rd1);
      acc0 = g0; acc1 = g1;
      n_rv0 = g0 && !we0;
      n_rv1 = g1 && !we1;
      n_rd0 = n_rv0 ? ref_mem[addr0] : m_rd0;
      n_rd1 = n_rv1 ? ref_mem[addr1] : m_rd1;
      wr_en = el; wr_addr = ea; wr_data = ed;
      n_holder = holder; n_streak = streak;
      if (holder < 0) begin
         n_holder = req0 ? 0 : (req1 ? 1 : -1);
         n_streak = 0;
      end else begin
         mine   = (holder == 0) ? req0 : req1;
         theirs = (holder == 0) ? req1 : req0;
         if (!mine && !theirs) begin
            n_holder = -1; n_streak = 0;
         end else if (!mine) begin
            n_holder = 1 - holder; n_streak = 0;
         end else if (!theirs) begin
            n_streak = 0;
         end else begin
            n_streak = streak + 1;
            if (n_streak == MAX_BURST) begin
               n_holder = 1 - holder; n_streak = 0;
            end
         end
      end
   endtask

   task automatic half();
      @(negedge clk);
      model_cycle();
   endtask

   task automatic fin();
      @(posedge clk);
      if (rst_n) begin
         holder = n_holder; streak = n_streak;
         m_rv0 = n_rv0; m_rv1 = n_rv1; m_rd0 = n_rd0; m_rd1 = n_rd1;
         if (wr_en) ref_mem[wr_addr] = wr_data;
      end
      #1;
   endtask

   task automatic new_req(output logic r, output logic w, output logic [14:0] a,
                          output logic [15:0] d);
      r = 1'b1;
      w = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 7))
         0:       a = 15'($urandom);
         1, 2, 3: a = 15'(32'h4000 + $urandom_range(0, 15));
         default: a = 15'($urandom_range(0, 15));
      endcase
      d = 16'($urandom);
   endtask

   typedef struct packed {
      logic r0; logic w0; logic [14:0] a0; logic [15:0] d0;
      logic r1; logic w1; logic [14:0] a1; logic [15:0] d1;
      logic eg0; logic eg1; logic eld; logic [14:0] ea;
      logic erv0; logic erv1; logic [15:0] erd0; logic [15:0] erd1;
   } vec_t;
   vec_t tbl [8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] pat [10];
      int  k, waited, last_idx;
      logic m0_seen, m1_pending;

      for (int i = 0; i < 32768; i++) begin
         env_mem[i] = 16'h0;
         ref_mem[i] = 16'h0;
      end
      for (int i = 0; i < 16; i++) begin
         env_mem[32'h4000 + i] = 16'(32'hA000 + i);
         ref_mem[32'h4000 + i] = 16'(32'hA000 + i);
      end

      //            r0 w0 a0        d0        r1 w1 a1        d1     g0 g1 ld ea        rv0 rv1 rd0       rd1
      tbl[0] = '{1'b1, 1'b1, 15'h0010, 16'h1234, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[1] = '{1'b1, 1'b1, 15'h0010, 16'h1234, 1'b0, 1'b0, 15'h0, 16'h0, 1'b1, 1'b0, 1'b1, 15'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[2] = '{1'b1, 1'b0, 15'h0010, 16'h1234, 1'b0, 1'b0, 15'h0, 16'h0, 1'b1, 1'b0, 1'b0, 15'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[3] = '{1'b0, 1'b0, 15'h0010, 16'h1234, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 1'b0, 15'h0010, 1'b1, 1'b0, 16'h1234, 16'h0000};
      tbl[4] = '{1'b0, 1'b0, 15'h0010, 16'h1234, 1'b1, 1'b0, 15'h4000, 16'h0, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h1234, 16'h0000};
      tbl[5] = '{1'b0, 1'b0, 15'h0010, 16'h1234, 1'b1, 1'b0, 15'h4000, 16'h0, 1'b0, 1'b1, 1'b0, 15'h4000, 1'b0, 1'b0, 16'h1234, 16'h0000};
      tbl[6] = '{1'b0, 1'b0, 15'h0010, 16'h1234, 1'b0, 1'b0, 15'h4000, 16'h0, 1'b0, 1'b0, 1'b0, 15'h4000, 1'b0, 1'b1, 16'h1234, 16'hA000};
      tbl[7] = '{1'b0, 1'b0, 15'h0010, 16'h1234, 1'b0, 1'b0, 15'h4000, 16'h0, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h1234, 16'hA000};

      // Reset held with random inputs: everything quiet.
      rst_n = 1'b1;
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
      #1 rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         new_req(req0, we0, addr0, wdata0);
         new_req(req1, we1, addr1, wdata1);
         half();
         chk("reset_quiet", {gnt0, gnt1, rv0, rv1, mem_load, mem_addr}, 32'h0);
         fin();
      end
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      rst_n = 1'b1;

      // Write/read round trip for m0, then m0 drops and m1 starts from IDLE.
      for (int i = 0; i < 8; i++) begin
         req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
         req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
         half();
         chk($sformatf("tbl%0d_gnt0", i), gnt0, tbl[i].eg0);
         chk($sformatf("tbl%0d_gnt1", i), gnt1, tbl[i].eg1);
         chk($sformatf("tbl%0d_load", i), mem_load, tbl[i].eld);
         chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].ea);
         chk($sformatf("tbl%0d_rv0", i), rv0, tbl[i].erv0);
         chk($sformatf("tbl%0d_rv1", i), rv1, tbl[i].erv1);
         chk($sformatf("tbl%0d_rd0", i), rd0, tbl[i].erd0);
         chk($sformatf("tbl%0d_rd1", i), rd1, tbl[i].erd1);
         fin();
      end

      // Both requesting from IDLE: none, then 0,0,0,0,1,1,1,1,0.
      pat[0] = 2'b00;
      for (int i = 1; i < 10; i++) pat[i] = (i >= 5 && i <= 8) ? 2'b10 : 2'b01;
      req0 = 1; we0 = 0; addr0 = 15'h0011;
      req1 = 1; we1 = 0; addr1 = 15'h4002;
      for (int i = 0; i < 10; i++) begin
         half();
         chk($sformatf("burst_seq%0d", i), {gnt1, gnt0}, pat[i]);
         fin();
      end
      req0 = 0; req1 = 0;
      half(); fin();

      // m1 streams screen words; m0 joins mid-burst and must get in within MAX_BURST.
      k = 0; waited = 0; last_idx = 0; m0_seen = 0; m1_pending = 0;
      req1 = 1; we1 = 0; addr1 = 15'h4000;
      for (int i = 0; i < 40 && !m0_seen; i++) begin
         half();
         if (rv1) chk("screen_rdata", rd1, 32'hA000 + last_idx);
         chk("screen_rvalid", rv1, m1_pending);
         m1_pending = gnt1;
         if (gnt0) m0_seen = 1;
         if (gnt1) begin
            last_idx = k;
            k++;
            if (req0) waited++;
         end
         fin();
         addr1 = 15'(32'h4000 + k);
         if (k == 2 && !req0) begin
            req0 = 1; we0 = 0; addr0 = 15'h0010;
         end
      end
      chk("m0_granted", m0_seen, 1'b1);
      chk("m0_wait_bound", waited <= MAX_BURST, 1'b1);
      req0 = 0; req1 = 0;
      half(); fin();
      half(); fin();

      // Reset falling inside an m1 write-grant cycle.
      req1 = 1; we1 = 0; addr1 = 15'h4000;
      half(); fin();
      half(); chk("pre_rst_gnt1", gnt1, 1'b1); fin();
      we1 = 1; addr1 = 15'h4001; wdata1 = 16'hBEEF;
      #1 rst_n = 1'b0;
      half();
      chk("rst_load", mem_load, 1'b0);
      chk("rst_gnt1", gnt1, 1'b0);
      chk("rst_rvalid1", rv1, 1'b0);
      chk("rst_rdata1", rd1, 16'h0000);
      fin();
      rst_n = 1'b1; req1 = 0; we1 = 0;
      chk("rst_mem_kept", env_mem[15'h4001], 16'hA001);
      req1 = 1; addr1 = 15'h4001;
      half(); chk("post_rst_idle", gnt1, 1'b0); fin();
      half(); chk("post_rst_gnt1", gnt1, 1'b1); fin();
      req1 = 0;
      half();
      chk("post_rst_rv1", rv1, 1'b1);
      chk("post_rst_rd1", rd1, 16'hA001);
      fin();

      // Random traffic against the reference model, with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if (acc0 || !req0) begin
            if ($urandom_range(0, 3) != 0) new_req(req0, we0, addr0, wdata0);
            else req0 = 0;
         end
         if (acc1 || !req1) begin
            if ($urandom_range(0, 3) != 0) new_req(req1, we1, addr1, wdata1);
            else req1 = 0;
         end
         rst_n = ($urandom_range(0, 249) != 0);
         half();
         fin();
      end
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
